fifo_rr_mux: RTL and testbench

//  Downstream consumer of NUM_SRC fifo instances; round-robin selects a non-empty fifo, pops one word,

---
 rtl/fifo_rr_mux_pkg.sv | 12 +
 rtl/fifo_rr_mux_rr_arbiter.sv | 27 ++
 rtl/fifo_rr_mux.sv | 102 ++++++++++
 tb/tb_fifo_rr_mux.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_mux_pkg.sv
// Shared types for the fifo_rr_mux round-robin drain stage.
package fifo_rr_mux_pkg;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    CAP  = 2'd1,
    SEND = 2'd2
  } mux_state_t;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/fifo_rr_mux_rr_arbiter.sv
// Combinational rotate-priority search: first requester after last_grant, wrapping mod NUM_SRC.
module rr_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SRC_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   last_grant,
  output logic               gnt_vld,
  output logic [SRC_W-1:0]   gnt_idx
);

  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    // Walk from the farthest offset down so the nearest requester is assigned last and wins.
    for (int off = int'(NUM_SRC); off >= 1; off--) begin
      idx = (int'(last_grant) + off) % int'(NUM_SRC);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = SRC_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_mux.sv
// Round-robin drain of NUM_SRC registered-output fifos onto a single valid/ready port.
// Define FIFO_RR_MUX_CNT_EN to add the o_word_cnt accepted-word counter.
module fifo_rr_mux
  import fifo_rr_mux_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned SRC_W      = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*FIFO_WIDTH-1:0] in_fifo_data,
  input  logic [NUM_SRC-1:0]            in_fifo_empty,
  output logic [NUM_SRC-1:0]            o_pop,
  output logic [FIFO_WIDTH-1:0]         o_data,
  output logic [SRC_W-1:0]              o_src,
  output logic                          o_valid,
`ifdef FIFO_RR_MUX_CNT_EN
  output logic [CNT_W-1:0]              o_word_cnt,
`endif
  input  logic                          i_ready
);

  mux_state_t           state;
  logic [SRC_W-1:0]     sel;
  logic [SRC_W-1:0]     last_grant;
  logic                 gnt_vld;
  logic [SRC_W-1:0]     gnt_idx;
  logic [FIFO_WIDTH-1:0] sel_data;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_arb (
    .req        (~in_fifo_empty),
    .last_grant (last_grant),
    .gnt_vld    (gnt_vld),
    .gnt_idx    (gnt_idx)
  );

  // Pop is a same-cycle strobe; the fifo presents the word on its output register next cycle.
  always_comb begin
    o_pop = '0;
    if (state == ARB && gnt_vld) begin
      o_pop[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      if (sel == SRC_W'(k)) begin
        sel_data = in_fifo_data[k*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      sel        <= '0;
      last_grant <= SRC_W'(NUM_SRC - 1);
      o_data     <= '0;
      o_src      <= '0;
      o_valid    <= 1'b0;
    end else begin
      unique case (state)
        ARB: begin
          if (gnt_vld) begin
            sel        <= gnt_idx;
            last_grant <= gnt_idx;
            state      <= CAP;
          end
        end
        CAP: begin
          o_data  <= sel_data;
          o_src   <= sel;
          o_valid <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

`ifdef FIFO_RR_MUX_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_word_cnt <= '0;
    end else if (o_valid && i_ready) begin
      o_word_cnt <= o_word_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rr_mux.sv
// Scoreboard bench for fifo_rr_mux: fifo-bank model drives the DUT, a monitor checks each handshake.
module tb_fifo_rr_mux;

  localparam int W = 16;
  localparam int N = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   src;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic [N*W-1:0] in_fifo_data;
  logic [N-1:0]   in_fifo_empty;
  logic [N-1:0]   o_pop;
  logic [W-1:0]   o_data;
  logic [1:0]     o_src;
  logic           o_valid;
  logic           i_ready;
`ifdef FIFO_RR_MUX_CNT_EN
  logic [15:0]    o_word_cnt;
`endif

  int checks;
  int errors;
  int cycle;
  int hs_cnt;

  exp_t       exp_q[$];
  int         hs_times[$];
  logic [W-1:0] fq[N][$];
  logic [W-1:0] out_reg[N];
  logic [N-1:0] pend;

  fifo_rr_mux #(
    .FIFO_WIDTH (W),
    .NUM_SRC    (N),
    .SRC_W      (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_fifo_data  (in_fifo_data),
    .in_fifo_empty (in_fifo_empty),
    .o_pop         (o_pop),
    .o_data        (o_data),
    .o_src         (o_src),
    .o_valid       (o_valid),
`ifdef FIFO_RR_MUX_CNT_EN
    .o_word_cnt    (o_word_cnt),
`endif
    .i_ready       (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  task automatic refresh();
    for (int k = 0; k < N; k++) begin
      in_fifo_data[k*W +: W] = out_reg[k];
      in_fifo_empty[k]       = (fq[k].size() == 0);
    end
  endtask

  task automatic load(input int k, input logic [W-1:0] w);
    fq[k].push_back(w);
    refresh();
  endtask

  task automatic expect_word(input logic [W-1:0] d, input logic [1:0] s);
    exp_t e;
    e.data = d;
    e.src  = s;
    exp_q.push_back(e);
  endtask

  // Fifo bank model: pop seen at negedge, output register loads just after the next posedge.
  always @(negedge clk) pend = o_pop;
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N; k++) begin
      if (pend[k] && fq[k].size() > 0) out_reg[k] = fq[k].pop_front();
    end
    refresh();
  end

  // Monitor: pop legality every cycle, scoreboard compare on every handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      check("pop_legal", {31'd0, ($onehot0(o_pop) && ((o_pop & in_fifo_empty) == '0))}, 32'd1);
      if (o_valid && i_ready) begin
        hs_cnt++;
        hs_times.push_back(cycle);
        if (exp_q.size() == 0) begin
          check("unexpected_word", {14'd0, o_data, o_src}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word_data", {16'd0, o_data}, {16'd0, e.data});
          check("word_src", {30'd0, o_src}, {30'd0, e.src});
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    exp_q.delete();
    hs_cnt = 0;
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!o_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid_seen"}, {31'd0, o_valid}, 32'd1);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cycle   = 0;
    hs_cnt  = 0;
    pend    = '0;
    i_ready = 1'b1;
    for (int k = 0; k < N; k++) out_reg[k] = '0;
    refresh();
    rst_n = 1'b0;
    #12;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: idle with all fifos empty
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", {o_data, 11'd0, o_pop, o_valid}, 32'd0);
    end
`ifdef FIFO_RR_MUX_CNT_EN
    check("cnt_reset", {16'd0, o_word_cnt}, 32'd0);
`endif

    // 2: single source, latency pop -> valid two cycles later
    @(posedge clk);
    #2;
    load(2, 16'hA5A5);
    expect_word(16'hA5A5, 2'd2);
    @(negedge clk);
    check("t2_pop", {28'd0, o_pop}, 32'h4);
    @(negedge clk);
    check("t2_cap", {27'd0, o_pop, o_valid}, 32'd0);
    @(negedge clk);
    check("t2_valid", {o_data, 14'd0, o_src}, {16'hA5A5, 16'd2});
    check("t2_valid_bit", {31'd0, o_valid}, 32'd1);
    drain("t2");

    // 3: all sources, rotating grants at one word per three cycles
    do_reset();
    @(posedge clk);
    #2;
    hs_times.delete();
    load(0, 16'h1100); load(0, 16'h1101);
    load(1, 16'h1110); load(1, 16'h1111);
    load(2, 16'h1120);
    load(3, 16'h1130);
    expect_word(16'h1100, 2'd0);
    expect_word(16'h1110, 2'd1);
    expect_word(16'h1120, 2'd2);
    expect_word(16'h1130, 2'd3);
    expect_word(16'h1101, 2'd0);
    expect_word(16'h1111, 2'd1);
    drain("t3");
    check("t3_hs_count", hs_times.size(), 6);
    for (int i = 1; i < hs_times.size(); i++) begin
      check("t3_spacing", hs_times[i] - hs_times[i-1], 3);
    end

    // 4: back-pressure holds the word; a source filling during SEND waits for ARB
    @(posedge clk);
    #2;
    i_ready = 1'b0;
    load(2, 16'h2222);
    expect_word(16'h2222, 2'd2);
    expect_word(16'h3333, 2'd0);
    wait_valid("t4");
    load(0, 16'h3333);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_hold", {o_data, 9'd0, o_pop, o_src, o_valid}, {16'h2222, 9'd0, 4'd0, 2'd2, 1'b1});
    end
    @(posedge clk);
    #2;
    i_ready = 1'b1;
    drain("t4");

    // 5: wrap from src3 to src0, skipping empty 1 and 2
    @(posedge clk);
    #2;
    load(3, 16'h4444);
    expect_word(16'h4444, 2'd3);
    drain("t5a");
    @(posedge clk);
    #2;
    load(0, 16'h5000);
    load(3, 16'h5003);
    expect_word(16'h5000, 2'd0);
    expect_word(16'h5003, 2'd3);
    drain("t5b");

    // 6: reset while SEND drops the word and restores priority to src0
    @(posedge clk);
    #2;
    i_ready = 1'b0;
    load(0, 16'h6000);
    wait_valid("t6");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_drop", {o_data, 15'd0, o_valid}, 32'd0);
    exp_q.delete();
    hs_cnt = 0;
`ifdef FIFO_RR_MUX_CNT_EN
    check("t6_cnt_reset", {16'd0, o_word_cnt}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #2;
    i_ready = 1'b1;
    load(0, 16'h7000);
    load(1, 16'h7001);
    expect_word(16'h7000, 2'd0);
    expect_word(16'h7001, 2'd1);
    drain("t6");
`ifdef FIFO_RR_MUX_CNT_EN
    check("t6_cnt", {16'd0, o_word_cnt}, hs_cnt);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
